// File: rtl/dm_responder_if.sv
// Data-memory port bundle between the CPU (master) and the memory responder (slave).
// DM_ADDR_CHECK_EN adds the err completion flag to the bundle.
interface dm_responder_if #(
  parameter int DATA_W = 16
);
  logic [15:0]       addr;
  logic              re;
  logic              we;
  logic [DATA_W-1:0] wrt_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              stall;
`ifdef DM_ADDR_CHECK_EN
  logic              err;
`endif

  modport master (
    output addr, re, we, wrt_data,
    input  rd_data, rd_valid, stall
`ifdef DM_ADDR_CHECK_EN
    , input err
`endif
  );

  modport slave (
    input  addr, re, we, wrt_data,
    output rd_data, rd_valid, stall
`ifdef DM_ADDR_CHECK_EN
    , output err
`endif
  );
endinterface

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: word-addressed storage with a fixed access
// latency and a registered stall so the CPU pipeline can be exercised against slow memory.
// Optional macro DM_ADDR_CHECK_EN: accesses with nonzero address bits above ADDR_W
// complete normally but are rejected (write dropped, read returns zero, err pulses).
// Without it the upper address bits are ignored and the address wraps modulo depth.
module dm_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2,
  parameter int DATA_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  dm_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter reload: the accept cycle plus the BUSY cycles plus DONE total LATENCY stall cycles.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_write_q, is_write_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              stall_q, stall_d;
  logic              mem_we;
  logic              addr_bad;
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

`ifdef DM_ADDR_CHECK_EN
  logic err_q, err_d;

  assign addr_bad = ((addr_q >> ADDR_W) != 16'd0);
  assign bus.err  = err_q;
`else
  logic unused_addr_hi;

  assign addr_bad       = 1'b0;
  assign unused_addr_hi = |(addr_q >> ADDR_W);
`endif

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.stall    = stall_q;

  // Next-state logic: accept one request in IDLE, count down in BUSY, perform the access in DONE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    stall_d    = 1'b0;
    mem_we     = 1'b0;
`ifdef DM_ADDR_CHECK_EN
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.re || bus.we) begin
          addr_d     = bus.addr;
          wdata_d    = bus.wrt_data;
          is_write_d = bus.we;
          cnt_d      = CNT_LOAD;
          stall_d    = 1'b1;
          state_d    = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall_d = 1'b1;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        if (is_write_q) begin
          mem_we = !addr_bad;
        end else begin
          rd_valid_d = 1'b1;
          rd_data_d  = addr_bad ? '0 : mem_q[addr_q[ADDR_W-1:0]];
        end
`ifdef DM_ADDR_CHECK_EN
        err_d = addr_bad;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers with synchronous reset; the latched request is left as-is on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      stall_q    <= 1'b0;
`ifdef DM_ADDR_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      stall_q    <= stall_d;
`ifdef DM_ADDR_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  // Latched request copies, so the requester's inputs are ignored while busy.
  always_ff @(posedge clk) begin
    addr_q     <= addr_d;
    wdata_q    <= wdata_d;
    is_write_q <= is_write_d;
  end

  // Storage array write port; not reset, and a write pending when reset hits is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[addr_q[ADDR_W-1:0]] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder (LATENCY=2, ADDR_W=8).
// Runs either build; the wrap test or the address-check test is chosen by DM_ADDR_CHECK_EN.
module tb_dm_responder;

  localparam int LAT = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dm_responder_if #(.DATA_W(16)) bus ();

  dm_responder #(
    .ADDR_W (8),
    .LATENCY(LAT),
    .DATA_W (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one access from an IDLE cycle and follow it to completion.
  // lat = cycles after acceptance until stall is low again (-1 on timeout).
  task automatic do_access(input logic [15:0] a, input logic [15:0] d,
                           input logic r, input logic w,
                           output int lat, output logic valid_seen,
                           output logic [15:0] data, output logic err_seen);
    int c;
    bus.addr     = a;
    bus.wrt_data = d;
    bus.re       = r;
    bus.we       = w;
    tick();
    bus.re = 1'b0;
    bus.we = 1'b0;
    lat        = -1;
    valid_seen = 1'b0;
    data       = 16'h0000;
    err_seen   = 1'b0;
    c          = 0;
    while (c < 20) begin
      if (bus.rd_valid === 1'b1) begin
        valid_seen = 1'b1;
        data       = bus.rd_data;
      end
`ifdef DM_ADDR_CHECK_EN
      if (bus.err === 1'b1) err_seen = 1'b1;
`endif
      if (bus.stall === 1'b0 && c > 0) begin
        lat = c;
        break;
      end
      tick();
      c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.addr = 16'h0; bus.wrt_data = 16'h0; bus.re = 1'b0; bus.we = 1'b0;
    tick(); tick();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rd_data: got %h expected 0000", bus.rd_data); end
`ifdef DM_ADDR_CHECK_EN
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    int lat; logic v; logic [15:0] d; logic e;
    // write 0xBEEF to 0x0010, watching stall cycle by cycle
    bus.addr = 16'h0010; bus.wrt_data = 16'hBEEF; bus.we = 1'b1; bus.re = 1'b0;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL wr_accept_stall: got %b expected 0", bus.stall); end
    tick();
    bus.we = 1'b0;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL wr_stall_c0: got %b expected 1", bus.stall); end
    tick();
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL wr_stall_c1: got %b expected 1", bus.stall); end
    tick();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL wr_stall_c2: got %b expected 0", bus.stall); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL wr_no_rd_valid: got %b expected 0", bus.rd_valid); end
    // read it back
    do_access(16'h0010, 16'h0000, 1'b1, 1'b0, lat, v, d, e);
    checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL rd_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (v !== 1'b1) begin errors++; $display("[TB] FAIL rd_valid_seen: got %b expected 1", v); end
    checks++; if (d !== 16'hBEEF) begin errors++; $display("[TB] FAIL rd_data_beef: got %h expected beef", d); end
    tick();
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL rd_valid_pulse_end: got %b expected 0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 16'hBEEF) begin errors++; $display("[TB] FAIL rd_data_hold: got %h expected beef", bus.rd_data); end
  endtask

  task automatic test_back_to_back();
    int lat; logic v; logic [15:0] d; logic e;
    logic exp_stall, exp_valid;
    do_access(16'h0003, 16'h0303, 1'b0, 1'b1, lat, v, d, e);
    tick();
    bus.addr = 16'h0003; bus.re = 1'b1; bus.we = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      exp_stall = (k % 3) != 0;
      exp_valid = (k > 0) && ((k % 3) == 0);
      checks++; if (bus.stall !== exp_stall) begin errors++; $display("[TB] FAIL b2b_stall[%0d]: got %b expected %b", k, bus.stall, exp_stall); end
      checks++; if (bus.rd_valid !== exp_valid) begin errors++; $display("[TB] FAIL b2b_rd_valid[%0d]: got %b expected %b", k, bus.rd_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (bus.rd_data !== 16'h0303) begin errors++; $display("[TB] FAIL b2b_rd_data[%0d]: got %h expected 0303", k, bus.rd_data); end
      end
      if (k == 9) bus.re = 1'b0;
      else tick();
    end
    tick();
  endtask

  task automatic test_both_high();
    int lat; logic v; logic [15:0] d; logic e;
    do_access(16'h0020, 16'h1234, 1'b1, 1'b1, lat, v, d, e);
    checks++; if (v !== 1'b0) begin errors++; $display("[TB] FAIL both_no_rd_valid: got %b expected 0", v); end
    checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL both_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (bus.rd_data !== 16'h0303) begin errors++; $display("[TB] FAIL both_rd_data_untouched: got %h expected 0303", bus.rd_data); end
    do_access(16'h0020, 16'h0000, 1'b1, 1'b0, lat, v, d, e);
    checks++; if (v !== 1'b1 || d !== 16'h1234) begin errors++; $display("[TB] FAIL both_readback: got valid %b data %h expected valid 1 data 1234", v, d); end
  endtask

`ifndef DM_ADDR_CHECK_EN
  task automatic test_wrap();
    int lat; logic v; logic [15:0] d; logic e;
    do_access(16'h0105, 16'hA5A5, 1'b0, 1'b1, lat, v, d, e);
    do_access(16'h0005, 16'h0000, 1'b1, 1'b0, lat, v, d, e);
    checks++; if (v !== 1'b1 || d !== 16'hA5A5) begin errors++; $display("[TB] FAIL wrap_read_0005: got valid %b data %h expected valid 1 data a5a5", v, d); end
    do_access(16'hFF05, 16'h0000, 1'b1, 1'b0, lat, v, d, e);
    checks++; if (v !== 1'b1 || d !== 16'hA5A5) begin errors++; $display("[TB] FAIL wrap_read_ff05: got valid %b data %h expected valid 1 data a5a5", v, d); end
  endtask
`else
  task automatic test_addr_check();
    int lat; logic v; logic [15:0] d; logic e;
    do_access(16'h0005, 16'h1111, 1'b0, 1'b1, lat, v, d, e);
    checks++; if (e !== 1'b0) begin errors++; $display("[TB] FAIL chk_good_wr_err: got %b expected 0", e); end
    do_access(16'h0105, 16'hA5A5, 1'b0, 1'b1, lat, v, d, e);
    checks++; if (e !== 1'b1) begin errors++; $display("[TB] FAIL chk_bad_wr_err: got %b expected 1", e); end
    checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL chk_bad_wr_latency: got %0d expected %0d", lat, LAT); end
    do_access(16'h0105, 16'h0000, 1'b1, 1'b0, lat, v, d, e);
    checks++; if (e !== 1'b1 || v !== 1'b1 || d !== 16'h0000) begin errors++; $display("[TB] FAIL chk_bad_rd: got err %b valid %b data %h expected err 1 valid 1 data 0000", e, v, d); end
    tick();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL chk_err_pulse_end: got %b expected 0", bus.err); end
    do_access(16'h0005, 16'h0000, 1'b1, 1'b0, lat, v, d, e);
    checks++; if (e !== 1'b0 || v !== 1'b1 || d !== 16'h1111) begin errors++; $display("[TB] FAIL chk_good_rd: got err %b valid %b data %h expected err 0 valid 1 data 1111", e, v, d); end
  endtask
`endif

  task automatic test_reset_mid_access();
    int lat; logic v; logic [15:0] d; logic e;
    do_access(16'h0001, 16'h7777, 1'b0, 1'b1, lat, v, d, e);
    bus.addr = 16'h0001; bus.wrt_data = 16'h5555; bus.we = 1'b1; bus.re = 1'b0;
    tick();
    bus.we = 1'b0;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy_stall: got %b expected 1", bus.stall); end
    rst = 1'b1;
    tick();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_stall: got %b expected 0", bus.stall); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_rd_valid: got %b expected 0", bus.rd_valid); end
    rst = 1'b0;
    tick();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL mid_after_reset_stall: got %b expected 0", bus.stall); end
    do_access(16'h0001, 16'h0000, 1'b1, 1'b0, lat, v, d, e);
    checks++; if (v !== 1'b1 || d !== 16'h7777) begin errors++; $display("[TB] FAIL mid_old_value: got valid %b data %h expected valid 1 data 7777", v, d); end
  endtask

  // Test sequence and summary.
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.addr = 16'h0; bus.wrt_data = 16'h0; bus.re = 1'b0; bus.we = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_both_high();
`ifndef DM_ADDR_CHECK_EN
    test_wrap();
`else
    test_addr_check();
`endif
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
